// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the convolution window scheduler.
//   state_t   : FSM state encoding (IDLE/RUN/DONE)
//   out_dim   : number of window positions along one axis
//   cnt_width : register width needed to count 0..n-1 (minimum 1)
package conv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned out_dim(input int unsigned img,
                                          input int unsigned k,
                                          input int unsigned stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear; wrap flags the increment
// that returns it to zero so counters can be chained fastest-first.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one
//   clr      : synchronous clear (wins over en)
//   cnt      : current count
//   wrap     : en while cnt is at MAX
module wrap_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  logic at_max;

  assign at_max = (cnt == WIDTH'(MAX));
  assign wrap   = en & at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_max ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks a KxK window over an IMG_H x IMG_W map and streams one read address
// per accepted beat, with accumulator clear/capture flags per window.
//   clk, rst          : clock, asynchronous active-high reset
//   start, abort      : begin a pass (IDLE only) / cancel back to IDLE
//   base_addr         : map base, latched on an accepted start
//   addr_valid/ready  : address beat handshake
//   addr              : read address of the current tap
//   acc_clr, acc_last : first / last tap of the current window
//   out_row, out_col  : output-map coordinates of the current window
//   busy, done        : in RUN / one-cycle completion pulse
module conv_window_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned K      = 5,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              acc_clr,
  output logic              acc_last,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int unsigned K_CW  = cnt_width(K);
  localparam int unsigned OC_CW = cnt_width(OUT_W);
  localparam int unsigned OR_CW = cnt_width(OUT_H);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [K_CW-1:0]   kc, kr;
  logic [OC_CW-1:0]  oc;
  logic [OR_CW-1:0]  orow;
  logic              kc_wrap, kr_wrap, oc_wrap, or_wrap;
  logic              start_acc, beat_en, cnt_clr;
  logic [31:0]       offset;

  // abort outranks both a pending start and the beat advance
  assign start_acc = (state == ST_IDLE) & start & ~abort;
  assign beat_en   = (state == ST_RUN) & addr_ready & ~abort;
  assign cnt_clr   = abort | start_acc;

  // Counter chain, fastest first: kc -> kr -> oc -> orow
  wrap_counter #(.WIDTH(K_CW), .MAX(K - 1)) u_kc (
    .clk(clk), .rst(rst), .en(beat_en), .clr(cnt_clr), .cnt(kc), .wrap(kc_wrap)
  );
  wrap_counter #(.WIDTH(K_CW), .MAX(K - 1)) u_kr (
    .clk(clk), .rst(rst), .en(kc_wrap), .clr(cnt_clr), .cnt(kr), .wrap(kr_wrap)
  );
  wrap_counter #(.WIDTH(OC_CW), .MAX(OUT_W - 1)) u_oc (
    .clk(clk), .rst(rst), .en(kr_wrap), .clr(cnt_clr), .cnt(oc), .wrap(oc_wrap)
  );
  wrap_counter #(.WIDTH(OR_CW), .MAX(OUT_H - 1)) u_or (
    .clk(clk), .rst(rst), .en(oc_wrap), .clr(cnt_clr), .cnt(orow), .wrap(or_wrap)
  );

  // State and base register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      base_q <= '0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        base_q <= base_addr;
      end
    end
  end

  // Next-state logic; or_wrap marks acceptance of the final beat
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_acc) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (or_wrap) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode registered state and counters only
  always_comb begin
    addr_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    addr       = '0;
    acc_clr    = 1'b0;
    acc_last   = 1'b0;
    out_row    = '0;
    out_col    = '0;
    offset     = (32'(orow) * STRIDE + 32'(kr)) * IMG_W + 32'(oc) * STRIDE + 32'(kc);
    case (state)
      ST_RUN: begin
        addr_valid = 1'b1;
        busy       = 1'b1;
        addr       = base_q + ADDR_W'(offset);
        acc_clr    = (kr == '0) && (kc == '0);
        acc_last   = (kr == K_CW'(K - 1)) && (kc == K_CW'(K - 1));
        out_row    = 8'(orow);
        out_col    = 8'(oc);
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: default 5x5/32x32 instance and a
// 2x2 stride-2 pooling instance on a 28x28 map.
module tb_conv_window_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, addr_ready;
  logic [9:0] base_addr;
  logic       addr_valid, acc_clr, acc_last, busy, done;
  logic [9:0] addr;
  logic [7:0] out_row, out_col;

  logic       p_start, p_abort, p_ready;
  logic [9:0] p_base;
  logic       p_valid, p_clr, p_last, p_busy, p_done;
  logic [9:0] p_addr;
  logic [7:0] p_row, p_col;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  conv_window_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .acc_clr(acc_clr), .acc_last(acc_last), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  conv_window_scheduler #(.IMG_W(28), .IMG_H(28), .K(2), .STRIDE(2), .ADDR_W(10)) pool (
    .clk(clk), .rst(rst), .start(p_start), .abort(p_abort), .base_addr(p_base),
    .addr_valid(p_valid), .addr_ready(p_ready), .addr(p_addr),
    .acc_clr(p_clr), .acc_last(p_last), .out_row(p_row), .out_col(p_col),
    .busy(p_busy), .done(p_done)
  );

  typedef struct {
    logic [9:0]  base;
    int unsigned beat;
    logic [9:0]  addr;
    logic        clr;
    logic        last;
    logic [7:0]  row;
    logic [7:0]  col;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Independent address model: decompose the beat index by division
  function automatic logic [9:0] model_addr(input int unsigned base, input int unsigned idx,
                                            input int unsigned k, input int unsigned s,
                                            input int unsigned w, input int unsigned ow);
    int unsigned c, r, x, y;
    c = idx % k;
    r = (idx / k) % k;
    x = (idx / (k * k)) % ow;
    y = idx / (k * k * ow);
    return 10'((base + (y * s + r) * w + x * s + c) % 1024);
  endfunction

  // One full default-config pass at ready=1, checked beat by beat
  task automatic run_full(input logic [9:0] b, input logic [9:0] exp_last);
    int unsigned beats, cyc, merr, idx;
    logic [9:0]  last_a;
    logic        e_clr, e_last;
    beats = 0; cyc = 0; merr = 0; last_a = '0;
    addr_ready = 1'b1;
    base_addr  = b;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (addr_valid && cyc < 25000) begin
      beats++;
      idx    = beats - 1;
      e_clr  = (idx % 25) == 0;
      e_last = (idx % 25) == 24;
      if (addr !== model_addr(b, idx, 5, 1, 32, 28) || acc_clr !== e_clr ||
          acc_last !== e_last || busy !== 1'b1 || done !== 1'b0)
        merr++;
      last_a = addr;
      foreach (vecs[i]) begin
        if (vecs[i].base == b && vecs[i].beat == beats) begin
          check($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
          check($sformatf("vec%0d_clr", i), acc_clr, vecs[i].clr);
          check($sformatf("vec%0d_last", i), acc_last, vecs[i].last);
          check($sformatf("vec%0d_row", i), out_row, vecs[i].row);
          check($sformatf("vec%0d_col", i), out_col, vecs[i].col);
        end
      end
      @(negedge clk);
      cyc++;
    end
    check("pass_beats", beats, 19600);
    check("pass_last_addr", last_a, exp_last);
    check("pass_model_errs", merr, 0);
    check("pass_done_pulse", done, 1);
    check("pass_busy_in_done", busy, 0);
    @(negedge clk);
    check("pass_done_one_cycle", done, 0);
    check("pass_idle_valid", addr_valid, 0);
  endtask

  initial begin
    int unsigned beats, merr, idx;
    logic [9:0]  exp8 [8];
    logic [9:0]  last_a;
    logic [7:0]  cmin, cmax;

    vecs[0] = '{base: 10'd0,    beat: 1,     addr: 10'd0,    clr: 1, last: 0, row: 0,  col: 0};
    vecs[1] = '{base: 10'd0,    beat: 25,    addr: 10'd132,  clr: 0, last: 1, row: 0,  col: 0};
    vecs[2] = '{base: 10'd0,    beat: 26,    addr: 10'd1,    clr: 1, last: 0, row: 0,  col: 1};
    vecs[3] = '{base: 10'd0,    beat: 701,   addr: 10'd32,   clr: 1, last: 0, row: 1,  col: 0};
    vecs[4] = '{base: 10'd0,    beat: 19600, addr: 10'd1023, clr: 0, last: 1, row: 27, col: 27};
    vecs[5] = '{base: 10'd1000, beat: 1,     addr: 10'd1000, clr: 1, last: 0, row: 0,  col: 0};
    vecs[6] = '{base: 10'd1000, beat: 25,    addr: 10'd108,  clr: 0, last: 1, row: 0,  col: 0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1; base_addr = '0;
    p_start = 1'b0; p_abort = 1'b0; p_ready = 1'b1; p_base = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", addr_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", busy, 0);

    // Full pass, base 0
    run_full(10'd0, 10'd1023);

    // Backpressure at beat 2
    base_addr = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("bp_beat1", addr, 0);
    @(negedge clk);
    check("bp_beat2", addr, 1);
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_addr%0d", i), addr, 1);
      check($sformatf("bp_hold_valid%0d", i), addr_valid, 1);
    end
    addr_ready = 1'b1;
    @(negedge clk);
    check("bp_beat3", addr, 2);
    check("bp_beat3_clr", acc_clr, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Start during RUN ignored, abort at beat 100, restart at base 5
    base_addr = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (addr_valid) begin
        beats++;
        start = (beats == 50);
        if (beats == 50) base_addr = 10'd7;
        if (beats == 51) check("ign_start_addr", addr, 2);
        if (beats == 100) begin
          check("abort_beat_addr", addr, 135);
          check("abort_beat_last", acc_last, 1);
          abort = 1'b1;
          break;
        end
      end
      @(negedge clk);
    end
    check("abort_reached", beats, 100);
    @(negedge clk);
    abort = 1'b0;
    check("abort_valid", addr_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_no_done", done, 0);
    @(negedge clk);
    check("abort_no_done_late", done, 0);
    base_addr = 10'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_addr", addr, 5);
    check("restart_clr", acc_clr, 1);
    check("restart_valid", addr_valid, 1);

    // Asynchronous reset mid-pass
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", addr_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_stay_idle_valid", addr_valid, 0);
    check("arst_stay_idle_busy", busy, 0);

    // Full pass with base 1000: address arithmetic wraps mod 1024
    run_full(10'd1000, 10'd999);

    // Pooling instance: 2x2 windows, stride 2, 28x28 map
    exp8[0] = 10'd0;  exp8[1] = 10'd1;  exp8[2] = 10'd28; exp8[3] = 10'd29;
    exp8[4] = 10'd2;  exp8[5] = 10'd3;  exp8[6] = 10'd30; exp8[7] = 10'd31;
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    beats = 0; merr = 0; last_a = '0; cmin = 8'd255; cmax = 8'd0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (!p_valid) break;
      beats++;
      idx = beats - 1;
      if (beats <= 8) check($sformatf("pool_addr%0d", beats), p_addr, exp8[beats-1]);
      if (p_addr !== model_addr(0, idx, 2, 2, 28, 14) ||
          p_clr !== ((idx % 4) == 0) || p_last !== ((idx % 4) == 3))
        merr++;
      if (p_col < cmin) cmin = p_col;
      if (p_col > cmax) cmax = p_col;
      last_a = p_addr;
      @(negedge clk);
    end
    check("pool_beats", beats, 784);
    check("pool_last_addr", last_a, 783);
    check("pool_col_min", cmin, 0);
    check("pool_col_max", cmax, 13);
    check("pool_model_errs", merr, 0);
    check("pool_done", p_done, 1);
    @(negedge clk);
    check("pool_done_cleared", p_done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
